mem_req_arbiter: RTL and testbench

Shares a single compute-cluster memory port between `NumReq` requesters (compute units), directly in front of the memory-to-AXI adapter. Picks one pending request per cycle with round-robin arbitration and registers it into a one-deep output stage. It extends the request ID with the requester index and routes each response back by that index. A per-requester outstanding-request counter throttles requesters that have too many transactions in flight.

---
 rtl/mem_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one compute-cluster memory port between NumReq requesters. Each cycle
// a round-robin arbiter picks one eligible request and registers it into a
// one-deep output stage. The outgoing ID carries the requester index in its
// LSBs so responses can be routed back. A per-requester in-flight counter
// throttles requesters that already have MaxOutstanding requests pending.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    per-requester request handshake
//   req_id_i/addr_i/...    per-requester request fields (we_mask all-zero = read)
//   rsp_valid_o            per-requester response strobe
//   rsp_id_o, rsp_data_o   response ID / data, shared by all requesters
//   mem_ready_i            downstream accepts the registered request
//   mem_req_*_o            registered downstream request, id = {req_id, index}
//   mem_rsp_*_i            downstream response (no backpressure)
module mem_req_arbiter #(
   parameter  int NumReq         = 4,
   parameter  int ReqIdWidth     = 4,
   parameter  int AddrWidth      = 32,
   parameter  int BlockBytes     = 16,
   parameter  int MaxOutstanding = 8,
   localparam int IdxW           = $clog2(NumReq),
   localparam int CntW           = $clog2(MaxOutstanding + 1),
   localparam int OutIdW         = ReqIdWidth + IdxW,
   localparam int DataW          = 8 * BlockBytes
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NumReq-1:0]                      req_valid_i,
   output logic [NumReq-1:0]                      req_ready_o,
   input  logic [NumReq-1:0][ReqIdWidth-1:0]      req_id_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]       req_addr_i,
   input  logic [NumReq-1:0][BlockBytes-1:0]      req_we_mask_i,
   input  logic [NumReq-1:0][DataW-1:0]           req_wdata_i,
   output logic [NumReq-1:0]                      rsp_valid_o,
   output logic [ReqIdWidth-1:0]                  rsp_id_o,
   output logic [DataW-1:0]                       rsp_data_o,
   input  logic                                   mem_ready_i,
   output logic                                   mem_req_valid_o,
   output logic [OutIdW-1:0]                      mem_req_id_o,
   output logic [AddrWidth-1:0]                   mem_req_addr_o,
   output logic [BlockBytes-1:0]                  mem_req_we_mask_o,
   output logic [DataW-1:0]                       mem_req_wdata_o,
   input  logic                                   mem_rsp_valid_i,
   input  logic [OutIdW-1:0]                      mem_rsp_id_i,
   input  logic [DataW-1:0]                       mem_rsp_data_i
);

   // Registered state
   logic                              r_out_valid;
   logic [OutIdW-1:0]                 r_out_id;
   logic [AddrWidth-1:0]              r_out_addr;
   logic [BlockBytes-1:0]             r_out_mask;
   logic [DataW-1:0]                  r_out_wdata;
   logic [IdxW-1:0]                   r_rr_ptr;
   logic [NumReq-1:0][CntW-1:0]       r_cnt;

   // Combinational helpers
   logic [NumReq-1:0]                 w_elig;
   logic                              w_found;
   logic [IdxW-1:0]                   w_winner;
   logic [IdxW-1:0]                   w_scan;
   logic                              w_advance;
   logic                              w_accept;
   logic [IdxW-1:0]                   w_rsp_idx;
   logic                              w_rsp_hit;
   logic [NumReq-1:0]                 w_inc;
   logic [NumReq-1:0]                 w_dec;
   logic [NumReq-1:0][CntW-1:0]       w_cnt_nxt;
   logic [IdxW-1:0]                   w_rr_nxt;

   assign w_advance = !r_out_valid || mem_ready_i;
   assign w_accept  = w_advance && w_found && !rst_i;

   // Responses whose index field points past the last requester are ignored.
   assign w_rsp_idx = mem_rsp_id_i[IdxW-1:0];
   assign w_rsp_hit = mem_rsp_valid_i && !rst_i &&
                      ({1'b0, w_rsp_idx} < (IdxW+1)'(NumReq));

   assign w_rr_nxt  = (w_winner == IdxW'(NumReq - 1)) ? '0 : (w_winner + IdxW'(1));

   // Eligibility: valid and below the in-flight limit (uses registered count,
   // so a response frees the slot only from the following cycle).
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NumReq; i++) begin
         w_elig[i] = req_valid_i[i] && (r_cnt[i] < CntW'(MaxOutstanding));
      end
   end

   // Round-robin search starting at r_rr_ptr, wrapping past NumReq-1.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_scan   = '0;
      for (int k = 0; k < NumReq; k++) begin
         w_scan = IdxW'((int'(r_rr_ptr) + k) % NumReq);
         if (!w_found && w_elig[w_scan]) begin
            w_found  = 1'b1;
            w_winner = w_scan;
         end else begin
            w_found  = w_found;
         end
      end
   end

   // Grant one-hot, response strobe decode and per-requester counter update.
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      w_inc       = '0;
      w_dec       = '0;
      w_cnt_nxt   = r_cnt;
      for (int i = 0; i < NumReq; i++) begin
         w_inc[i]       = w_accept && (w_winner == IdxW'(i));
         w_dec[i]       = w_rsp_hit && (w_rsp_idx == IdxW'(i));
         req_ready_o[i] = w_inc[i];
         rsp_valid_o[i] = w_dec[i];
         case ({w_inc[i], w_dec[i]})
            2'b10:   w_cnt_nxt[i] = r_cnt[i] + CntW'(1);
            // Decrement saturates at zero for stray responses.
            2'b01:   w_cnt_nxt[i] = (r_cnt[i] == '0) ? r_cnt[i] : (r_cnt[i] - CntW'(1));
            default: w_cnt_nxt[i] = r_cnt[i];
         endcase
      end
   end

   assign rsp_id_o   = mem_rsp_id_i[OutIdW-1:IdxW];
   assign rsp_data_o = mem_rsp_data_i;

   // Output stage, round-robin pointer and counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
         r_out_addr  <= '0;
         r_out_mask  <= '0;
         r_out_wdata <= '0;
         r_rr_ptr    <= '0;
         r_cnt       <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_id    <= {req_id_i[w_winner], w_winner};
            r_out_addr  <= req_addr_i[w_winner];
            r_out_mask  <= req_we_mask_i[w_winner];
            r_out_wdata <= req_wdata_i[w_winner];
            r_rr_ptr    <= w_rr_nxt;
         end else if (w_advance) begin
            // Previous beat taken (or stage empty) and nothing new: drain.
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
      end
   end

   assign mem_req_valid_o   = r_out_valid;
   assign mem_req_id_o      = r_out_id;
   assign mem_req_addr_o    = r_out_addr;
   assign mem_req_we_mask_o = r_out_mask;
   assign mem_req_wdata_o   = r_out_wdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter: reset, fairness, backpressure hold,
// throttling, response routing, simultaneous accept/response and mid-run reset.
module tb_mem_req_arbiter;

   logic                  clk;
   logic                  rst;
   logic [3:0]            req_valid;
   logic [3:0]            req_ready;
   logic [3:0][3:0]       req_id;
   logic [3:0][31:0]      req_addr;
   logic [3:0][15:0]      req_mask;
   logic [3:0][127:0]     req_wdata;
   logic [3:0]            rsp_valid;
   logic [3:0]            rsp_id;
   logic [127:0]          rsp_data;
   logic                  mem_ready;
   logic                  mreq_valid;
   logic [5:0]            mreq_id;
   logic [31:0]           mreq_addr;
   logic [15:0]           mreq_mask;
   logic [127:0]          mreq_wdata;
   logic                  mrsp_valid;
   logic [5:0]            mrsp_id;
   logic [127:0]          mrsp_data;

   int n_chk;
   int n_pass;
   int n_acc;

   mem_req_arbiter dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_id_i          (req_id),
      .req_addr_i        (req_addr),
      .req_we_mask_i     (req_mask),
      .req_wdata_i       (req_wdata),
      .rsp_valid_o       (rsp_valid),
      .rsp_id_o          (rsp_id),
      .rsp_data_o        (rsp_data),
      .mem_ready_i       (mem_ready),
      .mem_req_valid_o   (mreq_valid),
      .mem_req_id_o      (mreq_id),
      .mem_req_addr_o    (mreq_addr),
      .mem_req_we_mask_o (mreq_mask),
      .mem_req_wdata_o   (mreq_wdata),
      .mem_rsp_valid_i   (mrsp_valid),
      .mem_rsp_id_i      (mrsp_id),
      .mem_rsp_data_i    (mrsp_data)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus and checks.
   initial begin
      n_chk      = 0;
      n_pass     = 0;
      n_acc      = 0;
      rst        = 1'b1;
      req_valid  = 4'b1111;
      mem_ready  = 1'b1;
      mrsp_valid = 1'b1;
      mrsp_id    = {4'd7, 2'd1};
      mrsp_data  = 128'h0;
      for (int i = 0; i < 4; i++) begin
         req_id[i]    = 4'(i + 8);
         req_addr[i]  = 32'h0000_1000 + 32'(i) * 32'h10;
         req_mask[i]  = 16'h0001 << i;
         req_wdata[i] = {96'h0, 32'hA000_0000 + 32'(i)};
      end

      // Reset: outputs quiet even with requests and a response pending.
      tick();
      tick();
      chk("rst_mem_valid", 128'(mreq_valid), 128'h0);
      chk("rst_ready", 128'(req_ready), 128'h0);
      chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
      rst        = 1'b0;
      mrsp_valid = 1'b0;

      // Fairness: grants 0,1,2,3,0,1,2,3 and the registered id follows by one cycle.
      for (int k = 0; k < 8; k++) begin
         logic [1:0] g;
         g = 2'(k % 4);
         #1;
         chk("fair_ready", 128'(req_ready), 128'(4'b0001 << g));
         tick();
         chk("fair_valid", 128'(mreq_valid), 128'h1);
         chk("fair_id", 128'(mreq_id), 128'({req_id[g], g}));
         chk("fair_addr", 128'(mreq_addr), 128'(req_addr[g]));
         chk("fair_mask", 128'(mreq_mask), 128'(req_mask[g]));
      end

      // Mid-run reset with output valid and counts at 2 each.
      rst = 1'b1;
      #1;
      chk("mrst_ready", 128'(req_ready), 128'h0);
      tick();
      chk("mrst_mem_valid", 128'(mreq_valid), 128'h0);
      rst = 1'b0;
      #1;
      chk("mrst_restart0", 128'(req_ready), 128'h1);
      tick();
      chk("mrst_id", 128'(mreq_id), 128'({req_id[0], 2'd0}));
      req_valid = 4'b0000;
      #1;
      tick();
      chk("drain_valid", 128'(mreq_valid), 128'h0);

      // Response for requester 0 (count 1 -> 0), then a stray one at count 0.
      mrsp_valid = 1'b1;
      mrsp_id    = {4'd3, 2'd0};
      #1;
      chk("rsp0_valid", 128'(rsp_valid), 128'h1);
      chk("rsp0_id", 128'(rsp_id), 128'h3);
      tick();
      mrsp_id = {4'd4, 2'd0};
      #1;
      chk("stray0_valid", 128'(rsp_valid), 128'h1);
      chk("stray0_id", 128'(rsp_id), 128'h4);
      tick();

      // Routing: id {7,3}, data 0xDEAD, forwarded in the same cycle.
      mrsp_id   = {4'd7, 2'd3};
      mrsp_data = 128'hDEAD;
      #1;
      chk("route_valid", 128'(rsp_valid), 128'h8);
      chk("route_id", 128'(rsp_id), 128'h7);
      chk("route_data", rsp_data, 128'hDEAD);
      tick();
      mrsp_valid = 1'b0;

      // Backpressure: requester 2, id 5, addr 0x40, downstream stalled 3 cycles.
      mem_ready   = 1'b0;
      req_valid   = 4'b0100;
      req_id[2]   = 4'd5;
      req_addr[2] = 32'h40;
      #1;
      chk("bp_first_ready", 128'(req_ready), 128'h4);
      tick();
      req_id[2]   = 4'd9;
      req_addr[2] = 32'h80;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready_low", 128'(req_ready), 128'h0);
         tick();
         chk("bp_hold_valid", 128'(mreq_valid), 128'h1);
         chk("bp_hold_id", 128'(mreq_id), 128'({4'd5, 2'd2}));
         chk("bp_hold_addr", 128'(mreq_addr), 128'h40);
      end
      mem_ready = 1'b1;
      #1;
      chk("bp_release_ready", 128'(req_ready), 128'h4);
      tick();
      chk("bp_next_id", 128'(mreq_id), 128'({4'd9, 2'd2}));
      chk("bp_next_addr", 128'(mreq_addr), 128'h80);
      req_valid = 4'b0000;
      #1;
      tick();
      chk("bp_drain", 128'(mreq_valid), 128'h0);

      // Throttle: requester 1 alone, no responses -> exactly 8 acceptances.
      req_valid = 4'b0010;
      n_acc     = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (req_ready[1]) n_acc++;
         tick();
      end
      chk("thr_count", 128'(n_acc), 128'd8);
      #1;
      chk("thr_blocked", 128'(req_ready), 128'h0);
      req_valid = 4'b1010;
      #1;
      chk("thr_other_ok", 128'(req_ready), 128'h8);
      req_valid  = 4'b0010;
      mrsp_valid = 1'b1;
      mrsp_id    = {4'd2, 2'd1};
      #1;
      chk("thr_same_cycle", 128'(req_ready), 128'h0);
      chk("thr_rsp_valid", 128'(rsp_valid), 128'h2);
      tick();
      mrsp_valid = 1'b0;
      #1;
      chk("thr_next_cycle", 128'(req_ready), 128'h2);
      tick();
      req_valid = 4'b0000;
      #1;
      tick();

      // Simultaneous accept + response on requester 0: count stays at 1,
      // so only 7 more acceptances fit before throttling.
      req_valid = 4'b0001;
      #1;
      chk("sim_first", 128'(req_ready), 128'h1);
      tick();
      mrsp_valid = 1'b1;
      mrsp_id    = {4'd0, 2'd0};
      #1;
      chk("sim_ready", 128'(req_ready), 128'h1);
      chk("sim_rsp", 128'(rsp_valid), 128'h1);
      tick();
      mrsp_valid = 1'b0;
      n_acc      = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (req_ready[0]) n_acc++;
         tick();
      end
      chk("sim_count", 128'(n_acc), 128'd7);
      req_valid = 4'b0000;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
